// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: data width,
// FSM state encoding and a constant-friendly clog2 helper.
package arb_pkg;

    localparam int DATA_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting channel after the
// previous grant, wrapping around, as a one-hot vector.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Scanning offsets 1..N puts the previous winner last, which gives fairness.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int off = 1; off <= N; off++) begin
            if (!valid && req[(int'(last) + off) % N]) begin
                grant[(int'(last) + off) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter draining NUM_IN upstream FIFOs into one downstream
// FIFO, with a credit counter that keeps the downstream FIFO from overflowing.
module arbitro_rr
    import arb_pkg::*;
#(
    parameter  int NUM_IN    = 4,
    parameter  int OUT_DEPTH = 8,
    localparam int GW        = clog2(NUM_IN),
    localparam int CW        = clog2(OUT_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_empty,
    input  logic [DATA_W*NUM_IN-1:0] in_data,
    output logic [NUM_IN-1:0]        in_rd_en,
    input  logic                     out_pop,
    output logic                     out_wr_en,
    output logic [DATA_W-1:0]        out_data,
    output logic [GW-1:0]            grant_idx,
    output logic [CW-1:0]            credits,
    output logic [7:0]               word_count
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [NUM_IN-1:0] pick_grant;
    logic              pick_valid;
    logic              pop_ok;
    logic              issue;
    logic [GW-1:0]     issue_idx;
    logic [CW-1:0]     credits_next;
    logic              valid_q;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] lanes [NUM_IN];

    rr_pick #(
        .N  (NUM_IN),
        .IW (GW)
    ) u_pick (
        .req   (~in_empty),
        .last  (grant_idx),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign pop_ok   = (state != ST_STALL) && (credits != '0);
    assign issue    = pop_ok && pick_valid;
    assign in_rd_en = pop_ok ? pick_grant : '0;

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (pick_grant[i]) begin
                issue_idx = GW'(i);
            end
        end
    end

    // A reserved slot and a returned slot in the same cycle cancel out.
    always_comb begin
        credits_next = credits;
        if (issue && !out_pop) begin
            credits_next = credits - CW'(1);
        end else if (!issue && out_pop && (credits != CW'(OUT_DEPTH))) begin
            credits_next = credits + CW'(1);
        end
    end

    always_comb begin
        if (credits_next == '0) begin
            state_next = ST_STALL;
        end else if (&in_empty) begin
            state_next = ST_IDLE;
        end else begin
            state_next = ST_ACTIVE;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            lanes[i] = in_data[DATA_W*i +: DATA_W];
        end
    end

    // The upstream FIFO presents the popped word one cycle after rd_en.
    assign out_wr_en = valid_q;
    assign out_data  = valid_q ? lanes[grant_idx] : hold_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            credits    <= CW'(OUT_DEPTH);
            grant_idx  <= GW'(NUM_IN - 1);
            valid_q    <= 1'b0;
            hold_data  <= '0;
            word_count <= '0;
        end else begin
            state   <= state_next;
            credits <= credits_next;
            valid_q <= issue;
            if (issue) begin
                grant_idx <= issue_idx;
            end
            if (valid_q) begin
                hold_data  <= out_data;
                word_count <= word_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: upstream FIFOs modelled as small memories,
// downstream pushes checked in order against a scoreboard queue.
module tb_arbitro_rr;

    localparam int NUM_IN    = 4;
    localparam int OUT_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_empty;
    logic [15:0] in_data;
    logic [3:0]  in_rd_en;
    logic        out_pop;
    logic        out_wr_en;
    logic [3:0]  out_data;
    logic [1:0]  grant_idx;
    logic [3:0]  credits;
    logic [7:0]  word_count;

    logic [3:0]  mem [NUM_IN][16];
    int          head [NUM_IN];
    int          tail [NUM_IN];
    logic [3:0]  sb [$];
    logic [3:0]  rd_s;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          push_cnt = 0;

    arbitro_rr #(
        .NUM_IN    (NUM_IN),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_empty   (in_empty),
        .in_data    (in_data),
        .in_rd_en   (in_rd_en),
        .out_pop    (out_pop),
        .out_wr_en  (out_wr_en),
        .out_data   (out_data),
        .grant_idx  (grant_idx),
        .credits    (credits),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_empty();
        for (int k = 0; k < NUM_IN; k++) begin
            in_empty[k] = (head[k] == tail[k]);
        end
    endtask

    task automatic load_word(input int ch, input logic [3:0] w);
        mem[ch][tail[ch]] = w;
        tail[ch]++;
        refresh_empty();
    endtask

    // One clock: capture pops before the edge, update FIFO outputs after it,
    // then compare any downstream push against the scoreboard.
    task automatic cycle();
        logic [3:0] exp_w;
        #1;
        rd_s = in_rd_en;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rd_s[k]) begin
                in_data[4*k +: 4] = mem[k][head[k]];
                head[k]++;
            end
        end
        refresh_empty();
        @(negedge clk);
        if (out_wr_en) begin
            push_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_push", {31'b0, out_wr_en}, 32'd0);
            end else begin
                exp_w = sb.pop_front();
                check("push_data", {28'b0, out_data}, {28'b0, exp_w});
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        out_pop = 1'b0;
        in_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        refresh_empty();
        repeat (2) @(negedge clk);

        check("rst_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("rst_data", {28'b0, out_data}, 32'd0);
        check("rst_count", {24'b0, word_count}, 32'd0);
        check("rst_credits", {28'b0, credits}, 32'd8);
        check("rst_grant", {30'b0, grant_idx}, 32'd3);
        check("rst_rd_en", {28'b0, in_rd_en}, 32'd0);
        rst = 1'b0;
        cycle();
        check("idle_rd_en", {28'b0, in_rd_en}, 32'd0);

        // Two channels interleave.
        load_word(0, 4'hA); load_word(0, 4'hB);
        load_word(2, 4'h5); load_word(2, 4'h6);
        sb.push_back(4'hA); sb.push_back(4'h5); sb.push_back(4'hB); sb.push_back(4'h6);
        repeat (6) cycle();
        check("two_ch_pushes", push_cnt, 32'd4);
        check("two_ch_count", {24'b0, word_count}, 32'd4);
        check("two_ch_credits", {28'b0, credits}, 32'd4);
        out_pop = 1'b1;
        repeat (4) cycle();
        out_pop = 1'b0;
        check("refill_credits", {28'b0, credits}, 32'd8);

        // Single channel served back to back.
        load_word(3, 4'h1); load_word(3, 4'h2); load_word(3, 4'h3);
        sb.push_back(4'h1); sb.push_back(4'h2); sb.push_back(4'h3);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ch3_rd_en", {28'b0, in_rd_en}, 32'h8);
            cycle();
        end
        repeat (2) cycle();
        check("ch3_pushes", push_cnt, 32'd7);
        check("ch3_grant", {30'b0, grant_idx}, 32'd3);
        check("ch3_credits", {28'b0, credits}, 32'd5);
        out_pop = 1'b1;
        repeat (3) cycle();
        out_pop = 1'b0;
        check("refill2_credits", {28'b0, credits}, 32'd8);

        // Ten words queued, no downstream pops: credits run out after eight.
        for (int i = 0; i < 5; i++) begin
            load_word(0, 4'(4'h1 + i));
            load_word(1, 4'(4'h8 + i));
        end
        for (int i = 0; i < 5; i++) begin
            sb.push_back(4'(4'h1 + i));
            sb.push_back(4'(4'h8 + i));
        end
        repeat (12) cycle();
        check("stall_pushes", push_cnt, 32'd15);
        check("stall_credits", {28'b0, credits}, 32'd0);
        #1;
        check("stall_rd_en", {28'b0, in_rd_en}, 32'd0);
        out_pop = 1'b1;
        cycle();
        out_pop = 1'b0;
        repeat (4) cycle();
        check("one_more_push", push_cnt, 32'd16);
        check("restall_credits", {28'b0, credits}, 32'd0);

        // Pop issue and downstream pop in the same cycle with one credit.
        out_pop = 1'b1;
        cycle();
        cycle();
        check("simul_credits", {28'b0, credits}, 32'd1);
        check("simul_pushes", push_cnt, 32'd17);
        out_pop = 1'b0;
        load_word(2, 4'h7);
        sb.push_back(4'h7);
        #1;
        check("no_stall_rd_en", {28'b0, in_rd_en}, 32'h4);
        cycle();
        cycle();
        check("total_count", {24'b0, word_count}, 32'd18);
        check("after_credits", {28'b0, credits}, 32'd0);

        // Reset while a word is being pushed.
        out_pop = 1'b1;
        cycle();
        out_pop = 1'b0;
        load_word(0, 4'hE);
        sb.push_back(4'hE);
        cycle();
        check("pre_rst_wr_en", {31'b0, out_wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("mid_rst_credits", {28'b0, credits}, 32'd8);
        check("mid_rst_count", {24'b0, word_count}, 32'd0);
        check("mid_rst_grant", {30'b0, grant_idx}, 32'd3);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        check("post_rst_credits", {28'b0, credits}, 32'd8);
        check("post_rst_wr_en", {31'b0, out_wr_en}, 32'd0);
        check("post_rst_rd_en", {28'b0, in_rd_en}, 32'd0);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Round-robin arbiter that drains NUM_IN upstream 4-bit FIFOs into one downstream 4-bit FIFO. It pops one word per cycle from the next non-empty input and pushes it downstream one cycle later, aligned with the FIFO's registered read data. Flow control is a credit counter sized to the downstream FIFO depth, so the downstream FIFO can never overflow. The arbiter sits between the per-lane FIFOs and the shared output FIFO of the datapath.

## Interface
- NUM_IN, 4, number of upstream FIFOs (≥2)
- OUT_DEPTH, 8, downstream FIFO capacity in words (power of 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_empty  in  NUM_IN  buf_empty of each upstream FIFO
- in_data  in  4*NUM_IN  buf_out of each upstream FIFO, channel i at [4i+3:4i]
- in_rd_en  out  NUM_IN  one-hot pop to upstream FIFOs, combinational
- out_pop  in  1  downstream FIFO performed a successful pop this cycle (its rd_en && !buf_empty)
- out_wr_en  out  1  push to downstream FIFO, registered
- out_data  out  4  word to downstream FIFO
- grant_idx  out  clog2(NUM_IN)  channel of the current/last issued pop, registered
- credits  out  clog2(OUT_DEPTH)+1  free downstream slots not yet reserved
- word_count  out  8  words forwarded since reset, wraps 255→0

## Operation
- States: IDLE (all inputs empty), ACTIVE, STALL (credits==0).
- Pop issue in cycle N: in_rd_en[k]=1 iff state is not STALL, credits>0, and k is the first channel with in_empty[k]==0 searching from (grant_idx+1) mod NUM_IN upward, wrapping. At most one bit set. No pop when all inputs are empty.
- On a posedge with a pop issued: grant_idx←k, valid_q←1, credits decrement; otherwise valid_q←0.
- out_wr_en=valid_q; out_data=in_data[grant_idx] while valid_q=1, else holds its last value.
- word_count increments on every cycle with out_wr_en=1.
- Credits: a pop issue reserves one credit (−1), out_pop returns one (+1), both in the same cycle leave it unchanged. Credits never exceed OUT_DEPTH or go below 0.
- Transitions, evaluated every posedge:
  - IDLE→ACTIVE when any in_empty is 0.
  - ACTIVE→IDLE when all inputs are empty.
  - any state→STALL when the next credits value is 0.
  - STALL→ACTIVE/IDLE when credits>0, chosen by input emptiness.
- A channel that stays non-empty is served again only after every other non-empty channel has been served once (fairness).

## Timing
- Reset: state=IDLE, credits=OUT_DEPTH, grant_idx=NUM_IN-1 (so the first grant goes to channel 0), valid_q=0, out_wr_en=0, out_data=0, word_count=0, in_rd_en=0.
- Latency: a pop in cycle N gives out_wr_en=1 in cycle N+1 with the FIFO's buf_out on out_data.
- Throughput: 1 word/cycle while credits>0 and inputs are non-empty. Back-to-back grants rotate each cycle.
- IDLE→first pop takes one cycle. A pop may be issued combinationally in the same cycle the state is ACTIVE.
- STALL exit: a pop can issue in the cycle after out_pop raises credits from 0.
- Reset mid-operation: an in-flight word is discarded (out_wr_en forced to 0 immediately), and credits return to OUT_DEPTH. The downstream FIFO is reset together with the arbiter.

## Structure
- Package arb_pkg holds DATA_W=4, the state encoding (IDLE, ACTIVE, STALL), and the clog2 helper.
- Sub-module rr_pick is a combinational round-robin picker: inputs are the request vector (~in_empty) and the last grant; outputs are a one-hot grant and a grant-valid flag.
- The top level holds the FSM, credit counter, valid/grant registers, output mux, and word counter.

## Test plan
- Reset: after rst all outputs are 0, credits=8, grant_idx=3, and no in_rd_en while inputs are empty.
- Channels 0 and 2 each hold 2 words (0xA,0xB / 0x5,0x6): the push order downstream is A,5,B,6 on consecutive cycles, and word_count=4.
- Only channel 3 non-empty with 3 words: 3 consecutive pops on channel 3, out_wr_en high for 3 cycles with a one-cycle lag.
- 10 words queued, out_pop held 0: exactly 8 pushes, then STALL with credits=0 and no in_rd_en. One out_pop pulse → exactly one more push.
- Simultaneous pop issue and out_pop with credits=1: credits stays 1 and state does not enter STALL.
- rst asserted in the cycle after a pop: out_wr_en drops at once, and credits=8 after release.
